// File: rtl/spi_flash_sample_reader.sv
// Fetches one audio sample byte per request from a serial flash using a mode-0 SPI READ.
// The command/address go out MSB first and the final eight MISO bits become sample_out.
module spi_flash_sample_reader #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CS_GAP   = 4,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] addr_in,
    input  logic        req,
    output logic        ready,
    output logic [7:0]  sample_out,
    output logic        sample_valid,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [5:0]       LAST_BIT = 6'd39;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        GAP
    } state_t;

    state_t           state;
    logic [38:0]      shift_word;
    logic [7:0]       rx_data;
    logic [5:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;

    assign busy = ~ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shift_word   <= '0;
            rx_data      <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            gap_cnt      <= '0;
            ready        <= 1'b1;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            spi_cs_n     <= 1'b1;
            spi_sck      <= 1'b0;
            spi_mosi     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        // The 40-bit word {cmd, addr, 8'h00} is split: bit 39 goes
                        // straight to spi_mosi, the remaining 39 bits wait in shift_word.
                        spi_mosi   <= READ_CMD[7];
                        shift_word <= {READ_CMD[6:0], addr_in, 8'h00};
                        bit_cnt    <= '0;
                        div_cnt    <= '0;
                        ready      <= 1'b0;
                        spi_cs_n   <= 1'b0;
                        spi_sck    <= 1'b0;
                        state      <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                            rx_data <= {rx_data[6:0], spi_miso};
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                spi_cs_n     <= 1'b1;
                                spi_mosi     <= 1'b0;
                                sample_out   <= rx_data;
                                sample_valid <= 1'b1;
                                state        <= DONE;
                            end else begin
                                bit_cnt    <= bit_cnt + 6'd1;
                                spi_mosi   <= shift_word[38];
                                shift_word <= {shift_word[37:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                DONE: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    ready    <= 1'b1;
                    spi_cs_n <= 1'b1;
                    spi_sck  <= 1'b0;
                    spi_mosi <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_sample_reader.sv
// Directed bench: two reader instances (default and CLK_DIV=1/CS_GAP=1), each with a mode-0 flash model.
module tb_spi_flash_sample_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [23:0] addr0, addr1;
    logic        req0, req1;
    logic        ready0, ready1, sv0, sv1, busy0, busy1;
    logic [7:0]  sample0, sample1;
    logic        cs0, cs1, sck0, sck1, mosi0, mosi1;
    logic        miso0 = 1'b0, miso1 = 1'b0;

    spi_flash_sample_reader #(.CLK_DIV(2), .CS_GAP(4), .READ_CMD(8'h03)) dut0 (
        .clk(clk), .rst_n(rst_n), .addr_in(addr0), .req(req0), .ready(ready0),
        .sample_out(sample0), .sample_valid(sv0), .busy(busy0),
        .spi_cs_n(cs0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso0));

    spi_flash_sample_reader #(.CLK_DIV(1), .CS_GAP(1), .READ_CMD(8'h03)) dut1 (
        .clk(clk), .rst_n(rst_n), .addr_in(addr1), .req(req1), .ready(ready1),
        .sample_out(sample1), .sample_valid(sv1), .busy(busy1),
        .spi_cs_n(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] byte_for(input logic [23:0] a);
        case (a)
            24'h000000: return 8'hA5;
            24'h1FFFFF: return 8'h3C;
            24'h000010: return 8'h12;
            24'h000011: return 8'h34;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h96;
        endcase
    endfunction

    // Flash models: record MOSI on SCK rise, drive data MSB first on SCK fall after 32 bits.
    logic [39:0] rx0, rx1;
    logic [23:0] ra0, ra1;
    int          nb0 = 0, nb1 = 0;
    logic [7:0]  fb0, fb1;
    assign fb0 = byte_for(ra0);
    assign fb1 = byte_for(ra1);

    always @(posedge sck0 or posedge cs0) begin
        if (cs0) nb0 <= 0;
        else begin
            rx0 <= {rx0[38:0], mosi0};
            if (nb0 == 31) ra0 <= {rx0[22:0], mosi0};
            nb0 <= nb0 + 1;
        end
    end
    always @(negedge sck0) if (!cs0 && nb0 >= 32 && nb0 < 40) miso0 <= fb0[39-nb0];

    always @(posedge sck1 or posedge cs1) begin
        if (cs1) nb1 <= 0;
        else begin
            rx1 <= {rx1[38:0], mosi1};
            if (nb1 == 31) ra1 <= {rx1[22:0], mosi1};
            nb1 <= nb1 + 1;
        end
    end
    always @(negedge sck1) if (!cs1 && nb1 >= 32 && nb1 < 40) miso1 <= fb1[39-nb1];

    // Protocol monitors: sck low at cs toggles, mosi stable while sck high, no back-to-back strobes.
    logic pcs0 = 1'b1, psck0 = 1'b0, pmosi0 = 1'b0, psv0 = 1'b0;
    logic pcs1 = 1'b1, psck1 = 1'b0, pmosi1 = 1'b0, psv1 = 1'b0;
    int   viol0 = 0, viol1 = 0;
    always @(negedge clk) begin
        pcs0 <= cs0; psck0 <= sck0; pmosi0 <= mosi0; psv0 <= sv0;
        pcs1 <= cs1; psck1 <= sck1; pmosi1 <= mosi1; psv1 <= sv1;
        if ((cs0 !== pcs0 && sck0 !== 1'b0) || (!cs0 && sck0 && psck0 && mosi0 !== pmosi0) || (sv0 && psv0))
            viol0 <= viol0 + 1;
        if ((cs1 !== pcs1 && sck1 !== 1'b0) || (!cs1 && !pcs1 && sck1 === psck1) || (sv1 && psv1))
            viol1 <= viol1 + 1;
    end

    int pass_cnt = 0, tot_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_sv0(input int limit, output logic seen);
        int n = 0;
        while (!sv0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        seen = sv0;
    endtask

    task automatic read0(input logic [23:0] a, output int lat, output int cs_low,
                         output logic [7:0] data, output logic seen);
        int t0;
        int n = 0;
        while (!ready0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        addr0 = a;
        req0  = 1'b1;
        t0    = cyc;
        cs_low = 0;
        @(negedge clk);
        req0  = 1'b0;
        addr0 = ~a;
        n = 0;
        while (!sv0 && n < 1000) begin
            if (!cs0) cs_low++;
            @(negedge clk);
            n++;
        end
        seen = sv0;
        lat  = cyc - t0;
        data = sample0;
    endtask

    task automatic idle_check0(input string name, input int cycles);
        int low = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (!cs0) low++;
        end
        check(name, low, 0);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  data;
        int          lat;
        int          cs_low;
    } vec_t;

    vec_t vecs[4];

    initial begin : main
        int          lat, cs_low, t0, tv, hi, rdy_at, n;
        logic [7:0]  data;
        logic        seen;
        logic [23:0] ra[17];

        vecs[0] = '{addr: 24'h000000, data: 8'hA5, lat: 161, cs_low: 160};
        vecs[1] = '{addr: 24'h1FFFFF, data: 8'h3C, lat: 161, cs_low: 160};
        vecs[2] = '{addr: 24'hFFFFFF, data: 8'h69, lat: 161, cs_low: 160};
        vecs[3] = '{addr: 24'h0A5F00, data: 8'hC3, lat: 161, cs_low: 160};

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", ready0, 1'b1);
        check("rst_busy", busy0, 1'b0);
        check("rst_cs_n", cs0, 1'b1);
        check("rst_sck", sck0, 1'b0);
        check("rst_mosi", mosi0, 1'b0);
        check("rst_sample", sample0, 8'h00);
        check("rst_valid", sv0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            read0(vecs[i].addr, lat, cs_low, data, seen);
            check($sformatf("vec%0d_seen", i), seen, 1'b1);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_cs_low", i), cs_low, vecs[i].cs_low);
            check($sformatf("vec%0d_data", i), data, vecs[i].data);
            check($sformatf("vec%0d_mosi_word", i), rx0, {8'h03, vecs[i].addr, 8'h00});
            @(negedge clk);
            check($sformatf("vec%0d_valid_drop", i), sv0, 1'b0);
            repeat (8) @(negedge clk);
        end

        // Back-to-back with req held high.
        addr0 = 24'h000010; req0 = 1'b1; t0 = cyc;
        @(negedge clk);
        addr0 = 24'h000011;
        wait_sv0(1000, seen);
        tv = cyc;
        check("b2b_first_seen", seen, 1'b1);
        check("b2b_first_latency", tv - t0, 161);
        check("b2b_first_data", sample0, 8'h12);
        check("b2b_first_word", rx0, {8'h03, 24'h000010, 8'h00});
        @(negedge clk);
        hi = 0; rdy_at = -1; n = 0;
        while (cs0 && n < 50) begin
            if (ready0 && rdy_at < 0) rdy_at = cyc;
            hi++;
            @(negedge clk);
            n++;
        end
        check("b2b_ready_return", rdy_at - tv, 5);
        check("b2b_cs_high_cycles", hi, 5);
        req0 = 1'b0;
        t0 = tv + 5;
        wait_sv0(1000, seen);
        check("b2b_second_seen", seen, 1'b1);
        check("b2b_second_latency", cyc - t0, 161);
        check("b2b_second_data", sample0, 8'h34);
        check("b2b_second_word", rx0, {8'h03, 24'h000011, 8'h00});
        idle_check0("b2b_no_third", 200);

        // Request pulse during the address phase must be dropped.
        addr0 = 24'h000200; req0 = 1'b1; t0 = cyc;
        @(negedge clk);
        req0 = 1'b0;
        while (cyc < t0 + 40) @(negedge clk);
        addr0 = 24'h0ABCDE; req0 = 1'b1;
        check("busy_ready_low", ready0, 1'b0);
        @(negedge clk);
        req0 = 1'b0; addr0 = '0;
        wait_sv0(1000, seen);
        check("busy_seen", seen, 1'b1);
        check("busy_latency", cyc - t0, 161);
        check("busy_data", sample0, 8'h94);
        check("busy_word", rx0, {8'h03, 24'h000200, 8'h00});
        idle_check0("busy_no_extra", 300);

        // Asynchronous reset at bit 20 (second low cycle of that bit).
        addr0 = 24'h000300; req0 = 1'b1; t0 = cyc;
        @(negedge clk);
        req0 = 1'b0;
        while (cyc < t0 + 82) @(negedge clk);
        check("pre_reset_cs_low", cs0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n", cs0, 1'b1);
        check("mid_rst_sck", sck0, 1'b0);
        check("mid_rst_ready", ready0, 1'b1);
        check("mid_rst_busy", busy0, 1'b0);
        check("mid_rst_sample", sample0, 8'h00);
        check("mid_rst_valid", sv0, 1'b0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sv0) n++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sv0) n++;
        end
        check("mid_rst_no_valid", n, 0);
        read0(24'h000100, lat, cs_low, data, seen);
        check("post_rst_seen", seen, 1'b1);
        check("post_rst_latency", lat, 161);
        check("post_rst_cs_low", cs_low, 160);
        check("post_rst_data", data, 8'h97);
        check("post_rst_word", rx0, {8'h03, 24'h000100, 8'h00});

        // CLK_DIV=1, CS_GAP=1 instance: 16 random addresses, req held high throughout.
        for (int i = 0; i < 17; i++) ra[i] = 24'($urandom);
        addr1 = ra[0]; req1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n = 0;
            while (cs1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("sweep%0d_started", i), cs1, 1'b0);
            t0 = cyc - 1;
            if (i < 15) addr1 = ra[i+1];
            else req1 = 1'b0;
            n = 0;
            while (!sv1 && n < 500) begin
                @(negedge clk);
                n++;
            end
            tv = cyc;
            check($sformatf("sweep%0d_latency", i), tv - t0, 81);
            check($sformatf("sweep%0d_data", i), sample1, byte_for(ra[i]));
            check($sformatf("sweep%0d_word", i), rx1, {8'h03, ra[i], 8'h00});
            if (i < 15) begin
                @(negedge clk);
                hi = 0; n = 0;
                while (cs1 && n < 50) begin
                    hi++;
                    @(negedge clk);
                    n++;
                end
                check($sformatf("sweep%0d_gap", i), hi, 2);
            end
        end
        repeat (20) @(negedge clk);

        check("protocol_dut0", viol0, 0);
        check("protocol_dut1", viol1, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, tot_cnt);
        $fatal(1);
    end

endmodule
